// File: rtl/switch_conditioner_if.sv
// Switch conditioner signal bundle: raw switch levels in, debounced levels and edge strobes out.
// SWCOND_FREEZE_EN adds the freeze control.
interface switch_conditioner_if #(
   parameter int unsigned N_SW = 16
);
   logic [N_SW-1:0] sw_in;
   logic [N_SW-1:0] sw_out;
   logic [N_SW-1:0] sw_rise;
   logic [N_SW-1:0] sw_fall;
   logic            sw_changed;
`ifdef SWCOND_FREEZE_EN
   logic            freeze;
`endif

   // Board / consumer side.
   modport master (
`ifdef SWCOND_FREEZE_EN
      output freeze,
`endif
      output sw_in,
      input  sw_out,
      input  sw_rise,
      input  sw_fall,
      input  sw_changed
   );

   // Conditioner side.
   modport slave (
`ifdef SWCOND_FREEZE_EN
      input  freeze,
`endif
      input  sw_in,
      output sw_out,
      output sw_rise,
      output sw_fall,
      output sw_changed
   );
endinterface

// File: rtl/switch_conditioner.sv
// Per-bit 2-flop synchroniser, counter debounce and registered rise/fall strobes for board
// switches. Optional SWCOND_FREEZE_EN adds a freeze input that holds sw_out and masks strobes.
module switch_conditioner #(
   parameter int unsigned N_SW            = 16,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input logic                 CLK,
   input logic                 RST,
   switch_conditioner_if.slave sw
);
   localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [N_SW-1:0]  s1_q;
   logic [N_SW-1:0]  s2_q;
   logic [N_SW-1:0]  stable_q, stable_d;
   logic [N_SW-1:0]  out_q, out_d;
   logic [N_SW-1:0]  rise_q, rise_d;
   logic [N_SW-1:0]  fall_q, fall_d;
   logic             changed_q, changed_d;
   logic [CNT_W-1:0] cnt_q [N_SW];
   logic [CNT_W-1:0] cnt_d [N_SW];

   // A bit is accepted after DEBOUNCE_CYCLES consecutive mismatching edges; any agreement clears.
   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < int'(N_SW); i++) begin
         cnt_d[i] = '0;
         if (s2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               stable_d[i] = s2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   // Strobes derive from the visible output so they line up with its update edge.
   always_comb begin
`ifdef SWCOND_FREEZE_EN
      out_d = sw.freeze ? out_q : stable_d;
`else
      out_d = stable_d;
`endif
      rise_d    = out_d & ~out_q;
      fall_d    = ~out_d & out_q;
      changed_d = |(rise_d | fall_d);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         s1_q      <= '0;
         s2_q      <= '0;
         stable_q  <= '0;
         out_q     <= '0;
         rise_q    <= '0;
         fall_q    <= '0;
         changed_q <= 1'b0;
         for (int i = 0; i < int'(N_SW); i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         s1_q      <= sw.sw_in;
         s2_q      <= s1_q;
         stable_q  <= stable_d;
         out_q     <= out_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         changed_q <= changed_d;
         for (int i = 0; i < int'(N_SW); i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign sw.sw_out     = out_q;
   assign sw.sw_rise    = rise_q;
   assign sw.sw_fall    = fall_q;
   assign sw.sw_changed = changed_q;
endmodule

// File: tb/tb_switch_conditioner.sv
// Directed self-checking bench for switch_conditioner with DEBOUNCE_CYCLES=4.
// Observed vector layout: {sw_out, sw_rise, sw_fall, sw_changed}.
module tb_switch_conditioner;
   logic clk;
   logic rst;
   int   checks;
   int   failures;

   switch_conditioner_if #(.N_SW(16)) sw ();

   switch_conditioner #(
      .N_SW           (16),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .CLK(clk),
      .RST(rst),
      .sw (sw)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [48:0] obs();
      return {sw.sw_out, sw.sw_rise, sw.sw_fall, sw.sw_changed};
   endfunction

   task automatic apply_reset();
      rst = 1'b1;
      sw.sw_in = 16'h0000;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [48:0] got;
      rst = 1'b1;
      sw.sw_in = 16'hFFFF;
      step();
      step();
      got = obs();
      checks++;
      if (got !== 49'h0) begin
         failures++;
         $display("FAIL reset_state: got %h expected %h", got, 49'h0);
      end
      sw.sw_in = 16'h0000;
      step();
      rst = 1'b0;
      for (int k = 0; k < 8; k++) step();
      got = obs();
      checks++;
      if (got !== 49'h0) begin
         failures++;
         $display("FAIL reset_idle: got %h expected %h", got, 49'h0);
      end
   endtask

   task automatic test_single_rise();
      logic [48:0] got;
      logic        bad;
      apply_reset();
      sw.sw_in = 16'h0001;
      bad = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         if (obs() !== 49'h0) bad = 1'b1;
      end
      checks++;
      if (bad !== 1'b0) begin
         failures++;
         $display("FAIL rise_early: got change before edge E+5, expected none");
      end
      step();
      got = obs();
      checks++;
      if (got !== {16'h0001, 16'h0001, 16'h0000, 1'b1}) begin
         failures++;
         $display("FAIL rise_accept: got %h expected %h", got,
                  {16'h0001, 16'h0001, 16'h0000, 1'b1});
      end
      step();
      got = obs();
      checks++;
      if (got !== {16'h0001, 16'h0000, 16'h0000, 1'b0}) begin
         failures++;
         $display("FAIL rise_one_cycle: got %h expected %h", got,
                  {16'h0001, 16'h0000, 16'h0000, 1'b0});
      end
   endtask

   task automatic test_glitch();
      logic bad;
      apply_reset();
      bad = 1'b0;
      sw.sw_in = 16'h0008;
      for (int k = 0; k < 3; k++) begin
         step();
         if (obs() !== 49'h0) bad = 1'b1;
      end
      sw.sw_in = 16'h0000;
      for (int k = 0; k < 12; k++) begin
         step();
         if (obs() !== 49'h0) bad = 1'b1;
      end
      checks++;
      if (bad !== 1'b0) begin
         failures++;
         $display("FAIL glitch_3cyc: got output activity %0d expected 0", bad);
      end
   endtask

   task automatic test_back_to_back();
      logic [48:0] got;
      logic        bad;
      apply_reset();
      sw.sw_in = 16'h8001;
      for (int k = 0; k < 5; k++) step();
      step();
      got = obs();
      checks++;
      if (got !== {16'h8001, 16'h8001, 16'h0000, 1'b1}) begin
         failures++;
         $display("FAIL dual_rise: got %h expected %h", got,
                  {16'h8001, 16'h8001, 16'h0000, 1'b1});
      end
      step();
      got = obs();
      checks++;
      if (got !== {16'h8001, 16'h0000, 16'h0000, 1'b0}) begin
         failures++;
         $display("FAIL dual_rise_end: got %h expected %h", got,
                  {16'h8001, 16'h0000, 16'h0000, 1'b0});
      end
      sw.sw_in = 16'h0000;
      bad = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         if (obs() !== {16'h8001, 16'h0000, 16'h0000, 1'b0}) bad = 1'b1;
      end
      checks++;
      if (bad !== 1'b0) begin
         failures++;
         $display("FAIL dual_fall_early: got change before edge E+5, expected none");
      end
      step();
      got = obs();
      checks++;
      if (got !== {16'h0000, 16'h0000, 16'h8001, 1'b1}) begin
         failures++;
         $display("FAIL dual_fall: got %h expected %h", got,
                  {16'h0000, 16'h0000, 16'h8001, 1'b1});
      end
      step();
      got = obs();
      checks++;
      if (got !== 49'h0) begin
         failures++;
         $display("FAIL dual_fall_end: got %h expected %h", got, 49'h0);
      end
   endtask

   task automatic test_bounce();
      logic [48:0] got;
      logic        bad;
      apply_reset();
      bad = 1'b0;
      sw.sw_in = 16'h0020;
      for (int k = 0; k < 3; k++) begin
         step();
         if (obs() !== 49'h0) bad = 1'b1;
      end
      sw.sw_in = 16'h0000;
      step();
      if (obs() !== 49'h0) bad = 1'b1;
      sw.sw_in = 16'h0020;
      for (int k = 0; k < 5; k++) begin
         step();
         if (obs() !== 49'h0) bad = 1'b1;
      end
      checks++;
      if (bad !== 1'b0) begin
         failures++;
         $display("FAIL bounce_reject: got early acceptance expected none");
      end
      step();
      got = obs();
      checks++;
      if (got !== {16'h0020, 16'h0020, 16'h0000, 1'b1}) begin
         failures++;
         $display("FAIL bounce_accept: got %h expected %h", got,
                  {16'h0020, 16'h0020, 16'h0000, 1'b1});
      end
   endtask

   task automatic test_reset_mid_count();
      logic [48:0] got;
      apply_reset();
      sw.sw_in = 16'h0004;
      for (int k = 0; k < 6; k++) step();
      got = obs();
      checks++;
      if (got !== {16'h0004, 16'h0004, 16'h0000, 1'b1}) begin
         failures++;
         $display("FAIL midrst_setup: got %h expected %h", got,
                  {16'h0004, 16'h0004, 16'h0000, 1'b1});
      end
      // Bit 2 counts towards a fall: mismatch evaluated on two edges leaves count at 2.
      sw.sw_in = 16'h0000;
      for (int k = 0; k < 4; k++) step();
      rst = 1'b1;
      sw.sw_in = 16'h0004;
      step();
      got = obs();
      checks++;
      if (got !== 49'h0) begin
         failures++;
         $display("FAIL midrst_clear: got %h expected %h", got, 49'h0);
      end
      rst = 1'b0;
      for (int k = 0; k < 5; k++) step();
      got = obs();
      checks++;
      if (got !== 49'h0) begin
         failures++;
         $display("FAIL midrst_early: got %h expected %h", got, 49'h0);
      end
      step();
      got = obs();
      checks++;
      if (got !== {16'h0004, 16'h0004, 16'h0000, 1'b1}) begin
         failures++;
         $display("FAIL midrst_rise: got %h expected %h", got,
                  {16'h0004, 16'h0004, 16'h0000, 1'b1});
      end
   endtask

`ifdef SWCOND_FREEZE_EN
   task automatic test_freeze();
      logic [48:0] got;
      logic        bad;
      apply_reset();
      sw.freeze = 1'b1;
      sw.sw_in = 16'h00F0;
      bad = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (obs() !== 49'h0) bad = 1'b1;
      end
      checks++;
      if (bad !== 1'b0) begin
         failures++;
         $display("FAIL freeze_hold: got output activity while frozen expected none");
      end
      sw.freeze = 1'b0;
      step();
      got = obs();
      checks++;
      if (got !== {16'h00F0, 16'h00F0, 16'h0000, 1'b1}) begin
         failures++;
         $display("FAIL freeze_release: got %h expected %h", got,
                  {16'h00F0, 16'h00F0, 16'h0000, 1'b1});
      end
      step();
      got = obs();
      checks++;
      if (got !== {16'h00F0, 16'h0000, 16'h0000, 1'b0}) begin
         failures++;
         $display("FAIL freeze_one_cycle: got %h expected %h", got,
                  {16'h00F0, 16'h0000, 16'h0000, 1'b0});
      end
   endtask
`endif

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      sw.sw_in = 16'h0000;
`ifdef SWCOND_FREEZE_EN
      sw.freeze = 1'b0;
`endif
      test_reset();
      test_single_rise();
      test_glitch();
      test_back_to_back();
      test_bounce();
      test_reset_mid_count();
`ifdef SWCOND_FREEZE_EN
      test_freeze();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
